// File: rtl/pattern_moore_param.sv
// Parametrised Moore serial pattern detector.
// Shifts one bit in per enabled clock and flags when the newest len bits equal a
// runtime-loadable pattern. Supports overlapping and non-overlapping matching and
// keeps a saturating match counter. Outputs come straight from registers.
module pattern_moore_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0101),
    parameter int                 DEF_LEN     = 3,
    parameter logic               DEF_OVERLAP = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           a,
    input  logic                           en,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    output logic                           y,
    output logic [CNT_W-1:0]               match_count
);

    localparam int LW = $clog2(MAX_LEN + 1);

    // Registered state
    logic [MAX_LEN-1:0] hist_q;
    logic [LW-1:0]      fill_q;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LW-1:0]      len_q;
    logic               overlap_q;
    logic               y_q;
    logic [CNT_W-1:0]   count_q;

    // Next-state values
    logic [MAX_LEN-1:0] hist_d;
    logic [LW-1:0]      fill_d;
    logic [MAX_LEN-1:0] pattern_d;
    logic [LW-1:0]      len_d;
    logic               overlap_d;
    logic               y_d;
    logic [CNT_W-1:0]   count_d;

    // Helpers for the accepted-bit path
    logic [MAX_LEN-1:0] shifted;
    logic [LW-1:0]      fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      len_clamped;
    logic               match;

    // State register: synchronous active-low reset restores the power-on configuration.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (!reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= DEF_PATTERN;
            len_q     <= LW'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            y_q       <= 1'b0;
            count_q   <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            y_q       <= y_d;
            count_q   <= count_d;
        end
    end

    // Next-state logic: configuration load takes priority over an accepted bit.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        y_d       = y_q;
        count_d   = count_q;

        // Length 0 is meaningless and lengths beyond the shift register cannot match.
        if (cfg_len == '0) begin
            len_clamped = LW'(1);
        end else if (cfg_len > LW'(MAX_LEN)) begin
            len_clamped = LW'(MAX_LEN);
        end else begin
            len_clamped = cfg_len;
        end

        shifted  = {hist_q[MAX_LEN-2:0], a};
        fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);

        // Only the low len bits of history and pattern take part in the compare.
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        match = (fill_inc >= len_q) && (((shifted ^ pattern_q) & len_mask) == '0);

        if (cfg_load) begin
            // A bit arriving in the load cycle belongs to the old configuration and is dropped.
            pattern_d = cfg_pattern;
            len_d     = len_clamped;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            y_d       = 1'b0;
            count_d   = '0;
        end else if (en) begin
            hist_d = shifted;
            y_d    = match;
            // Non-overlapping mode demands len fresh bits after each match.
            fill_d = (match && !overlap_q) ? '0 : fill_inc;
            if (match && (count_q != '1)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Output logic: Moore outputs are the registered flag and counter.
    always_comb begin
        y           = y_q;
        match_count = count_q;
    end

endmodule

// File: tb/tb_pattern_moore_param.sv
// Testbench for pattern_moore_param: directed scenarios with hand-computed
// expectations, then randomized traffic compared every cycle against a
// behavioural model built on a queue of received bits. A second instance with a
// 2-bit counter exercises saturation on the same stimulus.
module tb_pattern_moore_param;

    localparam int MAX_LEN = 8;
    localparam int LW      = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a;
    logic          en;
    logic          cfg_load;
    logic [7:0]    cfg_pattern;
    logic [LW-1:0] cfg_len;
    logic          cfg_overlap;
    logic          y;
    logic [15:0]   cnt;
    logic          y_s;
    logic [1:0]    cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_moore_param #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .a(a), .en(en), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .y(y), .match_count(cnt)
    );

    pattern_moore_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .a(a), .en(en), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .y(y_s), .match_count(cnt_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         hq[$];       // accepted bits, newest at the back
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_since;     // bits eligible to form the next match
    bit         m_y;
    int         m_cnt16;
    int         m_cnt2;
    bit         model_valid = 1'b0;

    function automatic int eff_len(input logic [LW-1:0] l);
        if (l == 0) return 1;
        if (int'(l) > MAX_LEN) return MAX_LEN;
        return int'(l);
    endfunction

    always @(posedge clk) begin
        bit hit;
        if (reset === 1'b0) begin
            m_pat = 8'b0000_0101; m_len = 3; m_ovl = 1'b1;
            m_since = 0; hq.delete(); m_y = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
            model_valid = 1'b1;
        end else if (cfg_load) begin
            m_pat = cfg_pattern; m_len = eff_len(cfg_len); m_ovl = cfg_overlap;
            m_since = 0; hq.delete(); m_y = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
        end else if (en) begin
            hq.push_back(a);
            if (hq.size() > 16) void'(hq.pop_front());
            m_since++;
            hit = (m_since >= m_len);
            if (hit) begin
                for (int k = 0; k < m_len; k++) begin
                    if (hq[hq.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
            end
            m_y = hit;
            if (hit) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!m_ovl) m_since = 0;
            end
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("mdl_y", y, m_y);
            check("mdl_cnt", cnt, m_cnt16);
            check("mdl_y_sat", y_s, m_y);
            check("mdl_cnt_sat", cnt_s, m_cnt2);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive inputs just after a falling edge, return at the next falling edge.
    task automatic drive(input logic r, input logic e, input logic b, input logic ld);
        reset = r; en = e; a = b; cfg_load = ld;
        @(negedge clk);
    endtask

    task automatic send(input logic b);
        drive(1'b1, 1'b1, b, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [LW-1:0] len, input logic ovl,
                        input logic e, input logic b);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        drive(1'b1, e, b, 1'b1);
    endtask

    // Send n bits (bits[n-1] first) and check y after each against yexp.
    task automatic send_seq(input string nm, input logic [15:0] bits, input int n,
                            input logic [15:0] yexp);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i]);
            check($sformatf("%s_y%0d", nm, n - i), y, yexp[i]);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; a = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

        // 1: reset for two clocks, defaults detect 101 with overlap
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_y", y, 1'b0);
        check("rst_cnt", cnt, 16'd0);
        send_seq("t1", 16'b1011010, 7, 16'b0010010);
        check("t1_cnt", cnt, 16'd2);
        check("t1_cnt_sat", cnt_s, 2'd2);

        // 2: 1101, length 4, overlapping
        load(8'b1101, 4'd4, 1'b1, 1'b0, 1'b0);
        check("t2_load_cnt", cnt, 16'd0);
        send_seq("t2", 16'b1101101, 7, 16'b0001001);
        check("t2_cnt", cnt, 16'd2);

        // 3: same pattern, non-overlapping
        load(8'b1101, 4'd4, 1'b0, 1'b0, 1'b0);
        send_seq("t3", 16'b1101101, 7, 16'b0001000);
        check("t3_cnt", cnt, 16'd1);

        // 4: en gaps hold state
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        send_seq("t4a", 16'b10, 2, 16'b00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            check("t4_gap_y", y, 1'b0);
        end
        send(1'b1);
        check("t4_match_y", y, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check("t4_hold_y", y, 1'b1);
        end

        // 5: load with en=1 discards the bit; len 0 behaves as 1
        load(8'b1111_0001, 4'd0, 1'b1, 1'b1, 1'b1);
        check("t5_load_y", y, 1'b0);
        check("t5_load_cnt", cnt, 16'd0);
        send_seq("t5", 16'b1011, 4, 16'b1011);
        check("t5_cnt", cnt, 16'd3);

        // 5b: length above MAX_LEN clamps to 8
        load(8'b1010_1010, 4'd15, 1'b1, 1'b0, 1'b0);
        send_seq("t5b", 16'b1010_1010, 8, 16'b0000_0001);

        // 6: saturation on the 2-bit counter, then reset while y=1
        load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            send(1'b1);
            check("t6_cnt", cnt, 16'(i));
            check("t6_cnt_sat", cnt_s, (i >= 3) ? 2'd3 : 2'(i));
        end
        check("t6_y_pre", y, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("t6_rst_y", y, 1'b0);
        check("t6_rst_cnt", cnt, 16'd0);
        check("t6_rst_cnt_sat", cnt_s, 2'd0);
        // reset in the middle of a partial 101 clears history
        send_seq("t6p", 16'b10, 2, 16'b00);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        send_seq("t6q", 16'b101, 3, 16'b001);

        // Random traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            logic r, ld, e, b;
            r  = ($urandom_range(0, 99) != 0);
            ld = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            if (ld) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = ($urandom_range(0, 3) != 0) ? LW'($urandom_range(0, 4))
                                                          : LW'($urandom_range(0, 15));
                cfg_overlap = 1'($urandom);
            end
            drive(r, e, b, ld);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
